// File: rtl/cp0_intr_ctrl.sv
// cp0_intr_ctrl: Coprocessor-0 exception/interrupt sequencer.
// Holds Status/Cause/EPC, latches external IRQ edges into pending bits, and
// sequences an accepted exception through a fixed stall/flush drain period
// before redirecting fetch to the handler. eret redirects to EPC in the same cycle.
module cp0_intr_ctrl #(
    parameter int          NUM_IRQ      = 3,
    parameter logic [31:0] HANDLER_BASE = 32'h0000_0800,
    parameter int          DRAIN_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               inst_valid,
    input  logic [31:0]        pc_in,
    input  logic               syscall,
    input  logic               eret,
    input  logic               mtc0,
    input  logic [4:0]         cp0_sel,
    input  logic [31:0]        wdata,
    input  logic [NUM_IRQ-1:0] irq_in,
    output logic [31:0]        rdata,
    output logic               stall_req,
    output logic               flush,
    output logic               redirect,
    output logic [31:0]        redirect_pc,
    output logic [NUM_IRQ-1:0] irq_ack
);

    localparam logic [4:0] SEL_STATUS = 5'd12;
    localparam logic [4:0] SEL_CAUSE  = 5'd13;
    localparam logic [4:0] SEL_EPC    = 5'd14;
    localparam logic [4:0] EXC_INT    = 5'd0;
    localparam logic [4:0] EXC_SYS    = 5'd8;
    localparam int         CNT_W      = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam int         IDX_W      = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_TAKE  = 2'd2
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ie;
    logic [NUM_IRQ-1:0] r_mask;
    logic [NUM_IRQ-1:0] r_pend;
    logic [NUM_IRQ-1:0] r_irq_prev;
    logic [4:0]         r_exc;
    logic [31:0]        r_epc;
    logic [IDX_W-1:0]   r_irq_idx;
    logic               r_is_irq;

    logic               w_run_iv;
    logic [NUM_IRQ-1:0] w_rise;
    logic [NUM_IRQ-1:0] w_enabled;
    logic               w_irq_hit;
    logic               w_accept;
    logic               w_eret_go;
    logic               w_wr_status;
    logic               w_wr_cause;
    logic               w_wr_epc;
    logic [IDX_W-1:0]   w_pick;
    logic [NUM_IRQ-1:0] w_take_onehot;
    logic [NUM_IRQ-1:0] w_take_clr;
    logic [NUM_IRQ-1:0] w_keep;
    logic [NUM_IRQ-1:0] w_pend_nxt;

    // Instruction-boundary decode: only RUN with a retiring instruction acts.
    // Decisions use register values from before any same-cycle mtc0 write.
    assign w_run_iv    = (r_state == ST_RUN) && inst_valid;
    assign w_rise      = irq_in & ~r_irq_prev;
    assign w_enabled   = r_pend & r_mask;
    assign w_irq_hit   = r_ie && (|w_enabled) && !eret;
    assign w_accept    = w_run_iv && (syscall || w_irq_hit);
    assign w_eret_go   = w_run_iv && eret && !syscall;
    assign w_wr_status = w_run_iv && mtc0 && (cp0_sel == SEL_STATUS);
    assign w_wr_cause  = w_run_iv && mtc0 && (cp0_sel == SEL_CAUSE);
    assign w_wr_epc    = w_run_iv && mtc0 && (cp0_sel == SEL_EPC);

    // Lowest-index enabled pending IRQ wins arbitration.
    always_comb begin
        w_pick = '0;
        for (int k = NUM_IRQ - 1; k >= 0; k--) begin
            if (w_enabled[k]) begin
                w_pick = IDX_W'(k);
            end
        end
    end

    // Pending update: write-0-to-clear via mtc0 Cause, clear on take, set on a new edge.
    assign w_take_onehot = NUM_IRQ'(1) << r_irq_idx;
    assign w_take_clr    = ((r_state == ST_TAKE) && r_is_irq) ? w_take_onehot : '0;
    assign w_keep        = w_wr_cause ? wdata[8 +: NUM_IRQ] : '1;
    assign w_pend_nxt    = (r_pend & w_keep & ~w_take_clr) | w_rise;

    // IRQ edge detector and pending bits (edges are latched in every state).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq_prev <= '0;
            r_pend     <= '0;
        end else begin
            r_irq_prev <= irq_in;
            r_pend     <= w_pend_nxt;
        end
    end

    // Status: mask follows mtc0; IE is cleared on accept, set on eret, else written by mtc0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ie   <= 1'b0;
            r_mask <= '0;
        end else begin
            if (w_wr_status) begin
                r_mask <= wdata[8 +: NUM_IRQ];
            end
            if (w_accept) begin
                r_ie <= 1'b0;
            end else if (w_eret_go) begin
                r_ie <= 1'b1;
            end else if (w_wr_status) begin
                r_ie <= wdata[0];
            end
        end
    end

    // Exception context: EPC, ExcCode and taken IRQ are latched on accept; EPC also mtc0-writable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_epc     <= '0;
            r_exc     <= EXC_INT;
            r_irq_idx <= '0;
            r_is_irq  <= 1'b0;
        end else if (w_accept) begin
            r_epc     <= pc_in + 32'd4;
            r_exc     <= syscall ? EXC_SYS : EXC_INT;
            r_irq_idx <= w_pick;
            r_is_irq  <= !syscall;
        end else if (w_wr_epc) begin
            r_epc     <= wdata;
        end
    end

    // Sequencer: RUN -> DRAIN (DRAIN_CYCLES cycles) -> TAKE (one cycle) -> RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_accept) begin
                        r_state <= ST_DRAIN;
                        r_cnt   <= CNT_W'(DRAIN_CYCLES - 1);
                    end
                end
                ST_DRAIN: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_TAKE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_TAKE: begin
                    r_state <= ST_RUN;
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    // Pipeline control outputs decoded from the sequencer state plus the same-cycle eret path.
    always_comb begin
        stall_req   = 1'b0;
        flush       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        irq_ack     = '0;
        case (r_state)
            ST_DRAIN: begin
                stall_req = 1'b1;
                flush     = 1'b1;
            end
            ST_TAKE: begin
                flush       = 1'b1;
                redirect    = 1'b1;
                redirect_pc = HANDLER_BASE;
                irq_ack     = w_take_clr;
            end
            default: begin
                if (w_eret_go && rst_n) begin
                    flush       = 1'b1;
                    redirect    = 1'b1;
                    redirect_pc = r_epc;
                end
            end
        endcase
    end

    // mfc0 read mux; unmapped registers read as zero.
    always_comb begin
        case (cp0_sel)
            SEL_STATUS: rdata = (32'(r_mask) << 8) | 32'(r_ie);
            SEL_CAUSE:  rdata = (32'(r_pend) << 8) | (32'(r_exc) << 2);
            SEL_EPC:    rdata = r_epc;
            default:    rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_intr_ctrl.sv
// Testbench for cp0_intr_ctrl: directed scenarios plus randomized traffic, every
// cycle compared against a time-based behavioural model of the CP0 sequencer.
module tb_cp0_intr_ctrl;

    localparam int          N  = 3;
    localparam int          D  = 2;
    localparam logic [31:0] HB = 32'h0000_0800;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          inst_valid = 1'b0;
    logic [31:0]   pc_in = '0;
    logic          syscall = 1'b0;
    logic          eret = 1'b0;
    logic          mtc0 = 1'b0;
    logic [4:0]    cp0_sel = '0;
    logic [31:0]   wdata = '0;
    logic [N-1:0]  irq_in = '0;
    logic [31:0]   rdata;
    logic          stall_req;
    logic          flush;
    logic          redirect;
    logic [31:0]   redirect_pc;
    logic [N-1:0]  irq_ack;

    always #5 clk = ~clk;

    cp0_intr_ctrl #(
        .NUM_IRQ      (N),
        .HANDLER_BASE (HB),
        .DRAIN_CYCLES (D)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .inst_valid  (inst_valid),
        .pc_in       (pc_in),
        .syscall     (syscall),
        .eret        (eret),
        .mtc0        (mtc0),
        .cp0_sel     (cp0_sel),
        .wdata       (wdata),
        .irq_in      (irq_in),
        .rdata       (rdata),
        .stall_req   (stall_req),
        .flush       (flush),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .irq_ack     (irq_ack)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state: architectural registers plus elapsed time since accept.
    bit           m_ie;
    bit [N-1:0]   m_mask;
    bit [N-1:0]   m_pend;
    bit [N-1:0]   m_prev;
    bit [4:0]     m_exc;
    bit [31:0]    m_epc;
    bit           m_busy;
    int           m_since;
    int           m_taken;
    logic [31:0]  s_rdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit [31:0] m_read(input bit [4:0] sel);
        case (sel)
            5'd12:   return (32'(m_mask) * 256) + 32'(m_ie);
            5'd13:   return (32'(m_pend) * 256) + (32'(m_exc) * 4);
            5'd14:   return m_epc;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_ie = 0; m_mask = '0; m_pend = '0; m_prev = '0; m_exc = '0; m_epc = '0;
        m_busy = 0; m_since = 0; m_taken = -1;
    endtask

    task automatic idle_inputs();
        inst_valid = 0; pc_in = '0; syscall = 0; eret = 0; mtc0 = 0;
        cp0_sel = '0; wdata = '0; irq_in = '0;
    endtask

    // One clock: drive, compare outputs against the model, then advance the model at the edge.
    task automatic cycle(input bit iv, input bit [31:0] pc, input bit sy, input bit er,
                         input bit mt, input bit [4:0] sel, input bit [31:0] wd,
                         input bit [N-1:0] irq);
        bit          e_stall, e_red, e_flush;
        bit [31:0]   e_pc;
        bit [N-1:0]  e_ack, rise, en;
        bit          irq_ok;
        int          pick;
        @(negedge clk);
        inst_valid = iv; pc_in = pc; syscall = sy; eret = er; mtc0 = mt;
        cp0_sel = sel; wdata = wd; irq_in = irq;
        #1;
        e_stall = m_busy && (m_since <= D);
        e_red   = m_busy ? (m_since == D + 1) : (iv && er && !sy);
        e_flush = m_busy || e_red;
        e_pc    = !e_red ? 32'd0 : (m_busy ? HB : m_epc);
        e_ack   = (m_busy && m_since == D + 1 && m_taken >= 0) ? N'(1 << m_taken) : '0;
        check("stall_req", 32'(stall_req), 32'(e_stall));
        check("flush", 32'(flush), 32'(e_flush));
        check("redirect", 32'(redirect), 32'(e_red));
        check("redirect_pc", redirect_pc, e_pc);
        check("irq_ack", 32'(irq_ack), 32'(e_ack));
        check("rdata", rdata, m_read(sel));
        s_rdata = rdata;
        @(posedge clk);
        rise   = irq & ~m_prev;
        m_prev = irq;
        if (m_busy) begin
            if (m_since == D + 1) begin
                m_busy = 0;
                if (m_taken >= 0) m_pend[m_taken] = 1'b0;
            end else begin
                m_since++;
            end
        end else if (iv) begin
            en     = m_pend & m_mask;
            irq_ok = m_ie && (en != 0) && !er;
            pick   = -1;
            for (int k = 0; k < N; k++) if (en[k] && pick < 0) pick = k;
            if (mt) begin
                if (sel == 5'd12) begin m_ie = wd[0]; m_mask = wd[8 +: N]; end
                if (sel == 5'd13) m_pend = m_pend & wd[8 +: N];
                if (sel == 5'd14) m_epc = wd;
            end
            if (sy || irq_ok) begin
                m_epc   = pc + 32'd4;
                m_exc   = sy ? 5'd8 : 5'd0;
                m_taken = sy ? -1 : pick;
                m_ie    = 0;
                m_busy  = 1;
                m_since = 1;
            end else if (er) begin
                m_ie = 1;
            end
        end
        m_pend = m_pend | rise;
    endtask

    task automatic idle(input int n, input bit [4:0] sel);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, sel, 0, '0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    bit [N-1:0] r_irq;
    bit [31:0]  r_pc, r_wd;
    bit [4:0]   r_sel;

    initial begin
        idle_inputs();
        model_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_stall", 32'(stall_req), 32'd0);
        check("rst_flush", 32'(flush), 32'd0);
        check("rst_redirect", 32'(redirect), 32'd0);
        check("rst_redirect_pc", redirect_pc, 32'd0);
        check("rst_irq_ack", 32'(irq_ack), 32'd0);
        do_reset();

        // IRQ0 taken with Status=0x0101 at pc 0x100
        cycle(1, 0, 0, 0, 1, 5'd12, 32'h0101, '0);
        cycle(0, 0, 0, 0, 0, 5'd13, 0, 3'b001);
        cycle(1, 32'h100, 0, 0, 0, 5'd13, 0, '0);
        idle(D + 1, 5'd14);
        check("s1_epc", s_rdata, 32'h104);
        idle(1, 5'd12);
        check("s1_status", s_rdata, 32'h100);
        idle(1, 5'd13);
        check("s1_cause", s_rdata, 32'h0);

        // syscall at top of address space with IRQ0 pending but IE=0
        cycle(0, 0, 0, 0, 0, 5'd0, 0, 3'b001);
        cycle(0, 0, 0, 0, 0, 5'd0, 0, '0);
        cycle(1, 32'hFFFF_FFFC, 1, 0, 0, 5'd13, 0, '0);
        idle(D + 1, 5'd13);
        check("s3_cause", s_rdata, 32'h120);
        idle(1, 5'd14);
        check("s3_epc", s_rdata, 32'h0);

        // enable interrupts: pending IRQ0 accepted at next boundary, then reset mid-drain
        cycle(1, 32'h200, 0, 0, 1, 5'd12, 32'h0701, '0);
        cycle(1, 32'h204, 0, 0, 0, 5'd0, 0, '0);
        idle(1, 5'd0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("s6_stall", 32'(stall_req), 32'd0);
        check("s6_flush", 32'(flush), 32'd0);
        check("s6_redirect", 32'(redirect), 32'd0);
        do_reset();
        idle(D + 3, 5'd13);

        // eret together with an IRQ edge, then a long-held IRQ line
        cycle(1, 0, 0, 0, 1, 5'd12, 32'h0701, '0);
        cycle(1, 32'h300, 0, 0, 1, 5'd14, 32'h400, 3'b100);
        cycle(1, 32'h304, 0, 1, 0, 5'd14, 0, 3'b110);
        cycle(1, 32'h400, 0, 0, 0, 5'd13, 0, 3'b110);
        for (int i = 0; i < 20; i++) cycle(1, 32'h500 + 32'(4 * i), 0, i == 8, 0, 5'd13, 0, 3'b110);

        // randomized traffic
        r_irq = '0;
        for (int i = 0; i < 1500; i++) begin
            for (int k = 0; k < N; k++) if ($urandom_range(0, 9) < 2) r_irq[k] = ~r_irq[k];
            case ($urandom_range(0, 3))
                0: r_sel = 5'd12;
                1: r_sel = 5'd13;
                2: r_sel = 5'd14;
                default: r_sel = 5'($urandom);
            endcase
            r_pc = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFC : $urandom;
            r_wd = $urandom;
            if (r_sel == 5'd12 && $urandom_range(0, 1) == 1) r_wd[0] = 1'b1;
            if (r_sel == 5'd13 && $urandom_range(0, 1) == 1) r_wd[8 +: N] = '1;
            cycle($urandom_range(0, 9) < 7, r_pc, $urandom_range(0, 19) == 0,
                  $urandom_range(0, 11) == 0, $urandom_range(0, 6) == 0,
                  r_sel, r_wd, r_irq);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
